// File: rtl/pong_ball_ctrl.sv
// Pong ball sequencing controller: steps the ball per frame tick,
// bounces off walls and paddles, and keeps score until a player wins.
module pong_ball_ctrl #(
    parameter int X_MAX      = 39,
    parameter int Y_MAX      = 29,
    parameter int PAD_H      = 6,
    parameter int WIN_SCORE  = 7,
    parameter int HOLD_TICKS = 30,
    parameter int XW         = $clog2(X_MAX + 1),
    parameter int YW         = $clog2(Y_MAX + 1),
    parameter int SW         = $clog2(WIN_SCORE + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          tick,
    input  logic          serve,
    input  logic [YW-1:0] lpad_y,
    input  logic [YW-1:0] rpad_y,
    output logic [XW-1:0] ball_x,
    output logic [YW-1:0] ball_y,
    output logic [SW-1:0] score_l,
    output logic [SW-1:0] score_r,
    output logic          point_l,
    output logic          point_r,
    output logic          playing,
    output logic          game_over
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [XW-1:0] X_CTR  = XW'(X_MAX / 2);
    localparam logic [YW-1:0] Y_CTR  = YW'(Y_MAX / 2);
    localparam logic [XW-1:0] X_LAST = XW'(X_MAX);
    localparam logic [XW-1:0] X_PRE  = XW'(X_MAX - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_ZERO = '0;
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX);
    localparam logic [YW-1:0] Y_ZERO = '0;
    localparam logic [SW-1:0] S_WIN  = SW'(WIN_SCORE);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [YW:0]   PAD_SP = (YW+1)'(PAD_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    // dx: 1 = moving right, dy: 1 = moving down
    logic          dx_q, dx_d;
    logic          dy_q, dy_d;
    logic [SW-1:0] sl_q, sl_d;
    logic [SW-1:0] sr_q, sr_d;
    logic          pl_q, pl_d;
    logic          pr_q, pr_d;
    logic          play_q, play_d;
    logic          over_q, over_d;
    logic [HW-1:0] hold_q, hold_d;

    // Paddle range compares, one bit wider so a paddle past the
    // bottom wall never wraps around to the top.
    logic [YW:0] by_w;
    logic [YW:0] rtop_w, rbot_w;
    logic [YW:0] ltop_w, lbot_w;
    logic        rhit_w, lhit_w;

    assign by_w   = {1'b0, y_q};
    assign rtop_w = {1'b0, rpad_y};
    assign rbot_w = rtop_w + PAD_SP;
    assign ltop_w = {1'b0, lpad_y};
    assign lbot_w = ltop_w + PAD_SP;
    assign rhit_w = (by_w >= rtop_w) && (by_w <= rbot_w);
    assign lhit_w = (by_w >= ltop_w) && (by_w <= lbot_w);

    // Next-state and next-output logic for the game sequencer
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        pl_d    = 1'b0;
        pr_d    = 1'b0;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE: begin
                x_d = X_CTR;
                y_d = Y_CTR;
                if (serve) begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                if (tick) begin
                    if (dy_q && y_q == Y_LAST) begin
                        dy_d = 1'b0;
                        y_d  = y_q - 1'b1;
                    end else if (!dy_q && y_q == Y_ZERO) begin
                        dy_d = 1'b1;
                        y_d  = y_q + 1'b1;
                    end else if (dy_q) begin
                        y_d = y_q + 1'b1;
                    end else begin
                        y_d = y_q - 1'b1;
                    end

                    if (dx_q && x_q == X_PRE) begin
                        if (rhit_w) begin
                            dx_d = 1'b0;
                            x_d  = x_q - 1'b1;
                        end else begin
                            x_d     = X_LAST;
                            sl_d    = (sl_q == S_WIN) ? sl_q : sl_q + 1'b1;
                            pl_d    = 1'b1;
                            hold_d  = '0;
                            state_d = S_POINT;
                        end
                    end else if (!dx_q && x_q == X_ONE) begin
                        if (lhit_w) begin
                            dx_d = 1'b1;
                            x_d  = x_q + 1'b1;
                        end else begin
                            x_d     = X_ZERO;
                            sr_d    = (sr_q == S_WIN) ? sr_q : sr_q + 1'b1;
                            pr_d    = 1'b1;
                            hold_d  = '0;
                            state_d = S_POINT;
                        end
                    end else if (dx_q) begin
                        x_d = x_q + 1'b1;
                    end else begin
                        x_d = x_q - 1'b1;
                    end
                end
            end

            // dx still points at the player who conceded, so it
            // also identifies the scorer and the next serve direction.
            S_POINT: begin
                if (tick) begin
                    if (hold_q == H_LAST) begin
                        hold_d = '0;
                        if ((dx_q && sl_q == S_WIN) ||
                            (!dx_q && sr_q == S_WIN)) begin
                            state_d = S_OVER;
                        end else begin
                            state_d = S_IDLE;
                            x_d     = X_CTR;
                            y_d     = Y_CTR;
                            dy_d    = 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            S_OVER: begin
                if (serve) begin
                    state_d = S_IDLE;
                    sl_d    = '0;
                    sr_d    = '0;
                    x_d     = X_CTR;
                    y_d     = Y_CTR;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        play_d = (state_d == S_PLAY);
        over_d = (state_d == S_OVER);
    end

    // State and registered-output update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            sl_q    <= '0;
            sr_q    <= '0;
            pl_q    <= 1'b0;
            pr_q    <= 1'b0;
            play_q  <= 1'b0;
            over_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            sl_q    <= sl_d;
            sr_q    <= sr_d;
            pl_q    <= pl_d;
            pr_q    <= pr_d;
            play_q  <= play_d;
            over_q  <= over_d;
            hold_q  <= hold_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign point_l   = pl_q;
    assign point_r   = pr_q;
    assign playing   = play_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl: serve, wall bounce, paddle
// hits, misses, hold/re-center, game over and async reset.
module tb_pong_ball_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       serve;
    logic [4:0] lpad_y;
    logic [4:0] rpad_y;
    logic [5:0] ball_x;
    logic [4:0] ball_y;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic       point_l;
    logic       point_r;
    logic       playing;
    logic       game_over;

    int n_tests = 0;
    int n_fail  = 0;

    pong_ball_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .serve     (serve),
        .lpad_y    (lpad_y),
        .rpad_y    (rpad_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score_l   (score_l),
        .score_r   (score_r),
        .point_l   (point_l),
        .point_r   (point_r),
        .playing   (playing),
        .game_over (game_over)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ball_x), 32'(x));
        chk({tag, "_y"}, 32'(ball_y), 32'(y));
    endtask

    task automatic cyc(input logic t, input logic s);
        tick  = t;
        serve = s;
        @(posedge clock);
        #1;
        tick  = 1'b0;
        serve = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        tick   = 1'b0;
        serve  = 1'b0;
        lpad_y = 5'd12;
        rpad_y = 5'd20;
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // Reset state
        chk_ball("rst", 19, 14);
        chk("rst_sl", 32'(score_l), 0);
        chk("rst_sr", 32'(score_r), 0);
        chk("rst_play", 32'(playing), 0);
        chk("rst_over", 32'(game_over), 0);
        chk("rst_pl", 32'(point_l), 0);

        // Serve with tick: enters PLAY, no move that cycle
        cyc(1'b1, 1'b1);
        chk("srv_play", 32'(playing), 1);
        chk_ball("srv", 19, 14);
        cyc(1'b1, 1'b0);
        chk_ball("t1", 20, 15);

        // Bottom bounce
        ticks(14);
        chk_ball("t15", 34, 29);
        cyc(1'b1, 1'b0);
        chk_ball("t16", 35, 28);
        cyc(1'b0, 1'b0);
        chk_ball("notick", 35, 28);

        // Right paddle hit on its bottom row
        ticks(3);
        chk_ball("t19", 38, 25);
        cyc(1'b1, 1'b0);
        chk_ball("rhit", 37, 24);
        chk("rhit_sl", 32'(score_l), 0);
        chk("rhit_play", 32'(playing), 1);

        // Travel left, top bounce, left paddle hit on its top row
        ticks(36);
        chk_ball("lapp", 1, 12);
        cyc(1'b1, 1'b0);
        chk_ball("lhit", 2, 13);
        chk("lhit_sr", 32'(score_r), 0);
        chk("lhit_pr", 32'(point_r), 0);

        // Right misses repeatedly until left wins
        rpad_y = 5'd0;
        do_reset();
        for (int r = 1; r <= 7; r++) begin
            cyc(1'b1, 1'b1);
            ticks(19);
            chk_ball("pre", 38, 25);
            cyc(1'b1, 1'b0);
            chk_ball("miss", 39, 24);
            chk("miss_pl", 32'(point_l), 1);
            chk("miss_sl", 32'(score_l), 32'(r));
            chk("miss_play", 32'(playing), 0);
            cyc(1'b1, 1'b0);
            chk("pulse_end", 32'(point_l), 0);
            ticks(28);
            chk_ball("hold29", 39, 24);
            chk("hold29_over", 32'(game_over), 0);
            cyc(1'b1, 1'b0);
            if (r < 7) begin
                chk_ball("recenter", 19, 14);
                chk("rc_play", 32'(playing), 0);
                chk("rc_over", 32'(game_over), 0);
            end else begin
                chk("win_over", 32'(game_over), 1);
                chk_ball("win", 39, 24);
            end
        end
        chk("win_sr", 32'(score_r), 0);

        // Ticks ignored in OVER
        ticks(3);
        chk_ball("over_frz", 39, 24);
        chk("over_sl", 32'(score_l), 7);
        chk("over_hold", 32'(game_over), 1);

        // Serve restarts the game
        cyc(1'b0, 1'b1);
        chk("rst_g_over", 32'(game_over), 0);
        chk("rst_g_sl", 32'(score_l), 0);
        chk("rst_g_play", 32'(playing), 0);
        chk_ball("rst_g", 19, 14);
        cyc(1'b1, 1'b1);
        chk("g2_play", 32'(playing), 1);
        cyc(1'b1, 1'b0);
        chk_ball("g2_t1", 20, 15);

        // Score once, return to play, then async reset mid-cycle
        ticks(18);
        cyc(1'b1, 1'b0);
        chk("g2_sl", 32'(score_l), 1);
        ticks(30);
        cyc(1'b1, 1'b1);
        ticks(3);
        chk_ball("mid", 22, 17);
        #3;
        reset = 1'b1;
        #1;
        chk_ball("async", 19, 14);
        chk("async_sl", 32'(score_l), 0);
        chk("async_play", 32'(playing), 0);
        #2;
        reset = 1'b0;
        cyc(1'b1, 1'b1);
        chk("ar_play", 32'(playing), 1);
        chk_ball("ar_srv", 19, 14);
        cyc(1'b1, 1'b0);
        chk_ball("ar_t1", 20, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
